// File: rtl/adder_issue_unit_if.sv
// Issue-stage port bundle: instruction handshake, station write, result buses,
// branch resolution and debug regfile read.
interface adder_issue_unit_if;
  logic        inst_valid;
  logic [15:0] inst;
  logic        inst_ready;
  logic [1:0]  RAFilled;
  logic [3:0]  nextRA;
  logic        writeEnabled;
  logic [50:0] line;
  logic        floatOutReady;
  logic [15:0] floatOut;
  logic [3:0]  floatOutSrc;
  logic        isJeq;
  logic        jeqTaken;
  logic        loadOutReady;
  logic [15:0] loadOut;
  logic [3:0]  loadOutSrc;
  logic        branch_flush;
  logic        illegal_op;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;

  modport slave (
    input  inst_valid, inst, RAFilled, nextRA, floatOutReady, floatOut, floatOutSrc,
           isJeq, jeqTaken, loadOutReady, loadOut, loadOutSrc, rd_addr,
    output inst_ready, writeEnabled, line, branch_flush, illegal_op, rd_data
  );

  modport master (
    output inst_valid, inst, RAFilled, nextRA, floatOutReady, floatOut, floatOutSrc,
           isJeq, jeqTaken, loadOutReady, loadOut, loadOutSrc, rd_addr,
    input  inst_ready, writeEnabled, line, branch_flush, illegal_op, rd_data
  );
endinterface

// File: rtl/adder_issue_unit.sv
// In-order issue stage for the adder reservation station: queue, rename, regfile, jeq serialisation.
// Optional dispatch/stall counters are built when ISSUE_STATS_EN is defined.
module adder_issue_unit #(
  parameter int          IQ_DEPTH = 4,
  parameter logic [3:0]  TAG_NONE = 4'hF
) (
  input  logic clk,
  input  logic rst_n,
  adder_issue_unit_if.slave io
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_stall
`endif
);
  localparam int AW = $clog2(IQ_DEPTH);
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_JEQ  = 4'd6;

  typedef struct packed {
    logic [15:0] v;
    logic        rdy;
    logic [3:0]  src;
  } opnd_t;

  logic [IQ_DEPTH-1:0][15:0] q_q, q_d;
  logic [AW-1:0]             rp_q, rp_d, wp_q, wp_d;
  logic [AW:0]               cnt_q, cnt_d;
  logic [15:0][15:0]         reg_q, reg_d;
  logic [15:0][3:0]          stat_q, stat_d;
  logic                      jp_q, jp_d;

  logic [15:0] head;
  logic [3:0]  op, rd, ra, rb;
  logic        head_vld, flush, fwd_f, fwd_l, legal, go, dispatch, pop, push, illegal, ready;
  opnd_t       opa, opb;
  logic [50:0] line_c;

  function automatic opnd_t resolve(
    input logic [3:0] tag, input logic [15:0] rv,
    input logic ff, input logic [3:0] fs, input logic [15:0] fv,
    input logic lf, input logic [3:0] ls, input logic [15:0] lv);
    opnd_t o;
    o = '{v: 16'h0, rdy: 1'b0, src: tag};
    if (tag == TAG_NONE)       o = '{v: rv, rdy: 1'b1, src: TAG_NONE};
    else if (ff && tag == fs)  o = '{v: fv, rdy: 1'b1, src: TAG_NONE};
    else if (lf && tag == ls)  o = '{v: lv, rdy: 1'b1, src: TAG_NONE};
    return o;
  endfunction

  always_comb begin
    head     = q_q[rp_q];
    op       = head[15:12];
    rd       = head[11:8];
    ra       = head[7:4];
    rb       = head[3:0];
    head_vld = (cnt_q != '0);
    ready    = (cnt_q != (AW+1)'(IQ_DEPTH));
    flush    = io.isJeq && io.jeqTaken;
    // the float bus carries the branch outcome when isJeq is high, not a register result
    fwd_f    = io.floatOutReady && !io.isJeq;
    fwd_l    = io.loadOutReady;
    legal    = (op == OP_ADD) || (op == OP_ADDI) || (op == OP_JEQ);
    go       = head_vld && !jp_q && !flush;
    dispatch = go && legal && (io.nextRA != TAG_NONE) && (io.RAFilled < 2'd2);
    pop      = go && (!legal || dispatch);
    illegal  = go && !legal && (op != OP_NOP);
    push     = io.inst_valid && ready && !flush;

    opa = resolve(stat_q[ra], reg_q[ra], fwd_f, io.floatOutSrc, io.floatOut,
                  fwd_l, io.loadOutSrc, io.loadOut);
    opb = resolve(stat_q[rb], reg_q[rb], fwd_f, io.floatOutSrc, io.floatOut,
                  fwd_l, io.loadOutSrc, io.loadOut);
    if (op == OP_ADDI) opb = '{v: {12'h0, rb}, rdy: 1'b1, src: TAG_NONE};
    line_c = dispatch ? {rd, 1'b1, op, opa, opb} : '0;
  end

  always_comb begin
    q_d   = q_q;
    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (flush) begin
      rp_d  = wp_q;
      cnt_d = '0;
    end else begin
      if (push) begin
        q_d[wp_q] = io.inst;
        wp_d      = wp_q + 1'b1;
      end
      if (pop) rp_d = rp_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    reg_d  = reg_q;
    stat_d = stat_q;
    for (int r = 0; r < 16; r++) begin
      if (stat_q[r] != TAG_NONE) begin
        if (fwd_f && stat_q[r] == io.floatOutSrc) begin
          reg_d[r]  = io.floatOut;
          stat_d[r] = TAG_NONE;
        end else if (fwd_l && stat_q[r] == io.loadOutSrc) begin
          reg_d[r]  = io.loadOut;
          stat_d[r] = TAG_NONE;
        end
      end
    end
    // a rename of rd overrides a same-cycle clear; the value write above still lands
    if (dispatch && op != OP_JEQ) stat_d[rd] = io.nextRA;
    jp_d = jp_q;
    if (io.isJeq) jp_d = 1'b0;
    if (dispatch && op == OP_JEQ) jp_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      rp_q   <= '0;
      wp_q   <= '0;
      cnt_q  <= '0;
      reg_q  <= '0;
      stat_q <= {16{TAG_NONE}};
      jp_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      rp_q   <= rp_d;
      wp_q   <= wp_d;
      cnt_q  <= cnt_d;
      reg_q  <= reg_d;
      stat_q <= stat_d;
      jp_q   <= jp_d;
    end
  end

  assign io.inst_ready   = ready;
  assign io.writeEnabled = dispatch;
  assign io.line         = line_c;
  assign io.branch_flush = flush;
  assign io.illegal_op   = illegal;
  assign io.rd_data      = reg_q[io.rd_addr];

`ifdef ISSUE_STATS_EN
  logic [15:0] iss_q, iss_d, stl_q, stl_d;

  always_comb begin
    iss_d = iss_q;
    stl_d = stl_q;
    if (dispatch && iss_q != 16'hFFFF)              iss_d = iss_q + 16'd1;
    if (head_vld && !dispatch && stl_q != 16'hFFFF) stl_d = stl_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q <= '0;
      stl_q <= '0;
    end else begin
      iss_q <= iss_d;
      stl_q <= stl_d;
    end
  end

  assign stat_issued = iss_q;
  assign stat_stall  = stl_q;
`endif
endmodule

// File: tb/tb_adder_issue_unit.sv
// Bench for adder_issue_unit: directed scenarios plus a randomized run against a queue/array model.
module tb_adder_issue_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_issue_unit_if bus();
`ifdef ISSUE_STATS_EN
  logic [15:0] stat_issued, stat_stall;
`endif

  adder_issue_unit #(.IQ_DEPTH(4), .TAG_NONE(4'hF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
`ifdef ISSUE_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model: instruction list, architectural values, producer tags
  logic [15:0] m_q[$];
  logic [15:0] m_r[16];
  logic [3:0]  m_s[16];
  bit          m_jp;
  logic        e_we, e_flush, e_ill, e_rdy, e_pop, e_push;
  logic [50:0] e_line;

  function automatic logic [20:0] opnd(input logic [3:0] tag, input logic [15:0] rv);
    if (tag == 4'hF) return {rv, 1'b1, 4'hF};
    if (bus.floatOutReady && !bus.isJeq && bus.floatOutSrc == tag) return {bus.floatOut, 1'b1, 4'hF};
    if (bus.loadOutReady && bus.loadOutSrc == tag) return {bus.loadOut, 1'b1, 4'hF};
    return {16'h0, 1'b0, tag};
  endfunction

  function automatic void model_reset();
    m_q.delete();
    for (int r = 0; r < 16; r++) begin m_r[r] = 16'h0; m_s[r] = 4'hF; end
    m_jp = 0;
  endfunction

  function automatic void model_eval();
    logic [15:0] h;
    logic [3:0] op, rd, ra, rb;
    e_we = 0; e_ill = 0; e_pop = 0; e_line = '0;
    e_flush = bus.isJeq && bus.jeqTaken;
    e_rdy   = m_q.size() < 4;
    e_push  = bus.inst_valid && e_rdy && !e_flush;
    if (m_q.size() > 0 && !m_jp && !e_flush) begin
      h = m_q[0];
      {op, rd, ra, rb} = h;
      if (op == 4'd0) e_pop = 1;
      else if (op == 4'd1 || op == 4'd5 || op == 4'd6) begin
        if (bus.nextRA != 4'hF && bus.RAFilled < 2'd2) begin
          e_we = 1; e_pop = 1;
          e_line = {rd, 1'b1, op, opnd(m_s[ra], m_r[ra]),
                    (op == 4'd5) ? {12'h0, rb, 1'b1, 4'hF} : opnd(m_s[rb], m_r[rb])};
        end
      end else begin
        e_ill = 1; e_pop = 1;
      end
    end
  endfunction

  function automatic void model_commit();
    logic [15:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 16'h0;
    for (int r = 0; r < 16; r++) begin
      if (m_s[r] != 4'hF) begin
        if (bus.floatOutReady && !bus.isJeq && m_s[r] == bus.floatOutSrc) begin
          m_r[r] = bus.floatOut; m_s[r] = 4'hF;
        end else if (bus.loadOutReady && m_s[r] == bus.loadOutSrc) begin
          m_r[r] = bus.loadOut; m_s[r] = 4'hF;
        end
      end
    end
    if (e_we && h[15:12] != 4'd6) m_s[h[11:8]] = bus.nextRA;
    if (bus.isJeq) m_jp = 0;
    if (e_we && h[15:12] == 4'd6) m_jp = 1;
    if (e_flush) m_q.delete();
    else begin
      if (e_pop) void'(m_q.pop_front());
      if (e_push) m_q.push_back(bus.inst);
    end
  endfunction

  task automatic idle_inputs();
    bus.inst_valid = 0; bus.inst = 16'h0;
    bus.RAFilled = 2'd0; bus.nextRA = 4'd0;
    bus.floatOutReady = 0; bus.floatOut = 16'h0; bus.floatOutSrc = 4'h0;
    bus.isJeq = 0; bus.jeqTaken = 0;
    bus.loadOutReady = 0; bus.loadOut = 16'h0; bus.loadOutSrc = 4'h8;
    bus.rd_addr = 4'h0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic adv();
    model_commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int a = 0; a < 16; a += 5) begin
      bus.rd_addr = 4'(a);
      #1;
      n_chk++;
      if ({bus.writeEnabled, bus.line, bus.branch_flush, bus.illegal_op, bus.inst_ready, bus.rd_data}
          !== {1'b0, 51'h0, 1'b0, 1'b0, 1'b1, 16'h0}) begin
        n_fail++;
        $display("FAIL reset[r%0d]: we=%b line=%h bf=%b ill=%b rdy=%b rd=%h, need 0 0 0 0 1 0",
                 a, bus.writeEnabled, bus.line, bus.branch_flush, bus.illegal_op, bus.inst_ready, bus.rd_data);
      end
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_rename_forward();
    logic ok;
    for (int c = 0; c < 11; c++) begin
      idle_inputs();
      case (c)
        0: begin bus.inst_valid = 1; bus.inst = 16'h1312; bus.nextRA = 4'd0; end
        2: begin bus.inst_valid = 1; bus.inst = 16'h5435; bus.nextRA = 4'd1; end
        3: bus.nextRA = 4'd1;
        4: begin bus.floatOutReady = 1; bus.floatOutSrc = 4'd0; bus.floatOut = 16'h0007; end
        5: bus.rd_addr = 4'd3;
        6: begin bus.inst_valid = 1; bus.inst = 16'h1312; bus.nextRA = 4'd2; end
        7: bus.nextRA = 4'd2;
        8: begin bus.inst_valid = 1; bus.inst = 16'h1533; bus.nextRA = 4'd3; end
        9: begin bus.nextRA = 4'd3; bus.floatOutReady = 1; bus.floatOutSrc = 4'd2; bus.floatOut = 16'h0009; end
        10: bus.rd_addr = 4'd3;
        default: ;
      endcase
      settle();
      n_chk++;
      if ({bus.writeEnabled, bus.line, bus.rd_data} !== {e_we, e_line, m_r[bus.rd_addr]}) begin
        n_fail++;
        $display("FAIL rename_model[c%0d]: got we=%b line=%h rd=%h, need we=%b line=%h rd=%h",
                 c, bus.writeEnabled, bus.line, bus.rd_data, e_we, e_line, m_r[bus.rd_addr]);
      end
      ok = 1;
      case (c)
        0: ok = (bus.writeEnabled === 1'b0);
        1: ok = (bus.writeEnabled === 1'b1) && (bus.line[50:42] === {4'd3, 1'b1, 4'd1})
                && (bus.line[25:21] === 5'b1_1111) && (bus.line[4:0] === 5'b1_1111);
        3: ok = (bus.writeEnabled === 1'b1) && (bus.line[25:21] === 5'b0_0000)
                && (bus.line[20:5] === 16'd5) && (bus.line[4:0] === 5'b1_1111);
        5: ok = (bus.rd_data === 16'h0007);
        9: ok = (bus.writeEnabled === 1'b1) && (bus.line[41:21] === {16'h9, 1'b1, 4'hF})
                && (bus.line[20:0] === {16'h9, 1'b1, 4'hF});
        10: ok = (bus.rd_data === 16'h0009);
        default: ok = 1;
      endcase
      if (c inside {0, 1, 3, 5, 9, 10}) begin
        n_chk++;
        if (!ok) begin
          n_fail++;
          $display("FAIL rename_plan[c%0d]: we=%b line=%h rd=%h differs from planned values",
                   c, bus.writeEnabled, bus.line, bus.rd_data);
        end
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      if (c < 5) begin
        bus.RAFilled = 2'd2; bus.nextRA = 4'hF;
        bus.inst_valid = 1; bus.inst = {4'd1, 4'(6 + c), 8'h00};
      end else bus.nextRA = 4'd4;
      settle();
      n_chk++;
      if ({bus.writeEnabled, bus.line, bus.inst_ready} !== {e_we, e_line, e_rdy}) begin
        n_fail++;
        $display("FAIL bp_model[c%0d]: got we=%b line=%h rdy=%b, need we=%b line=%h rdy=%b",
                 c, bus.writeEnabled, bus.line, bus.inst_ready, e_we, e_line, e_rdy);
      end
      n_chk++;
      if (c < 5 && bus.writeEnabled !== 1'b0 || c == 4 && bus.inst_ready !== 1'b0 ||
          c >= 5 && c < 9 && (bus.writeEnabled !== 1'b1 || bus.line[50:47] !== 4'(6 + c - 5)) ||
          c == 9 && bus.writeEnabled !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_plan[c%0d]: we=%b rd=%0d rdy=%b", c, bus.writeEnabled, bus.line[50:47], bus.inst_ready);
      end
      adv();
    end
  endtask

  task automatic test_jeq_flush();
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      bus.nextRA = 4'd5;
      if (c == 0) begin bus.inst_valid = 1; bus.inst = 16'h6012; end
      if (c == 1) begin bus.inst_valid = 1; bus.inst = 16'h1A12; end
      if (c == 4) begin bus.isJeq = 1; bus.jeqTaken = 1; bus.inst_valid = 1; bus.inst = 16'h1C12; end
      settle();
      n_chk++;
      if ({bus.writeEnabled, bus.line, bus.branch_flush} !== {e_we, e_line, e_flush}) begin
        n_fail++;
        $display("FAIL jeq_model[c%0d]: got we=%b line=%h bf=%b, need we=%b line=%h bf=%b",
                 c, bus.writeEnabled, bus.line, bus.branch_flush, e_we, e_line, e_flush);
      end
      n_chk++;
      if ((c == 1) ? !(bus.writeEnabled === 1'b1 && bus.line[45:42] === 4'd6)
                   : (bus.writeEnabled !== 1'b0 || bus.branch_flush !== (c == 4))) begin
        n_fail++;
        $display("FAIL jeq_plan[c%0d]: we=%b op=%0d bf=%b", c, bus.writeEnabled, bus.line[45:42], bus.branch_flush);
      end
      adv();
    end
  endtask

  task automatic test_illegal();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c == 0) begin bus.inst_valid = 1; bus.inst = 16'h3123; end
      if (c == 1) begin bus.inst_valid = 1; bus.inst = 16'h1B12; end
      settle();
      n_chk++;
      if ({bus.writeEnabled, bus.line, bus.illegal_op} !== {e_we, e_line, e_ill}) begin
        n_fail++;
        $display("FAIL ill_model[c%0d]: got we=%b line=%h ill=%b, need we=%b line=%h ill=%b",
                 c, bus.writeEnabled, bus.line, bus.illegal_op, e_we, e_line, e_ill);
      end
      n_chk++;
      if (bus.illegal_op !== (c == 1) || bus.writeEnabled !== (c == 2)) begin
        n_fail++;
        $display("FAIL ill_plan[c%0d]: ill=%b we=%b", c, bus.illegal_op, bus.writeEnabled);
      end
      adv();
    end
  endtask

  task automatic test_random();
    int k;
    logic [3:0] op;
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      k = $urandom_range(0, 9);
      op = (k == 0) ? 4'd0 : (k <= 4 || k == 9) ? 4'd1 : (k <= 6) ? 4'd5 : (k == 7) ? 4'd6 : 4'(3 + $urandom_range(0, 1) * 4);
      bus.inst_valid = ($urandom_range(0, 3) != 0);
      bus.inst = {op, 12'($urandom())};
      bus.RAFilled = 2'($urandom_range(0, 2));
      bus.nextRA = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      bus.floatOutReady = ($urandom_range(0, 2) == 0);
      bus.floatOutSrc = 4'($urandom_range(0, 7));
      bus.floatOut = 16'($urandom());
      bus.loadOutReady = ($urandom_range(0, 3) == 0);
      bus.loadOutSrc = 4'($urandom_range(8, 14));
      bus.loadOut = 16'($urandom());
      bus.rd_addr = 4'($urandom());
      if (m_jp && $urandom_range(0, 3) == 0) begin
        bus.isJeq = 1; bus.jeqTaken = 1'($urandom_range(0, 1)); bus.floatOutReady = 0;
      end
      settle();
      n_chk++;
      if ({bus.writeEnabled, bus.line, bus.inst_ready, bus.branch_flush, bus.illegal_op, bus.rd_data}
          !== {e_we, e_line, e_rdy, e_flush, e_ill, m_r[bus.rd_addr]}) begin
        n_fail++;
        $display("FAIL random[c%0d]: got we=%b line=%h rdy=%b bf=%b ill=%b rd=%h, need %b %h %b %b %b %h",
                 c, bus.writeEnabled, bus.line, bus.inst_ready, bus.branch_flush, bus.illegal_op, bus.rd_data,
                 e_we, e_line, e_rdy, e_flush, e_ill, m_r[bus.rd_addr]);
      end
      adv();
    end
  endtask

  task automatic test_midreset();
    idle_inputs();
    bus.inst_valid = 1; bus.inst = 16'h1312;
    bus.floatOutReady = 1; bus.floatOutSrc = 4'd0; bus.floatOut = 16'h00AA;
    bus.rd_addr = 4'd3;
    #3;
    rst_n = 0;
    model_reset();
    #1;
    idle_inputs();
    bus.rd_addr = 4'd3;
    #1;
    n_chk++;
    if ({bus.writeEnabled, bus.line, bus.inst_ready, bus.rd_data} !== {1'b0, 51'h0, 1'b1, 16'h0}) begin
      n_fail++;
      $display("FAIL midreset: we=%b line=%h rdy=%b rd=%h, need 0 0 1 0",
               bus.writeEnabled, bus.line, bus.inst_ready, bus.rd_data);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    model_reset();
    test_rename_forward();
    test_backpressure();
    test_jeq_flush();
    test_illegal();
    test_random();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
